fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with one-outstanding instruction fetch, stall hold buffer and IF/ID register.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_CHK_EN.
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallf,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        pcSrce,
  input  logic [31:0] pcTargete,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcPlus4d,
  output logic        validd,
  output logic        misalignd,
  output logic        fetch_wait
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MIS_EN = 1'b1;
  logic [31:0] target;
  logic        target_mis;
  assign target     = pcTargete;
  assign target_mis = |pcTargete[1:0];
`else
  localparam logic MIS_EN = 1'b0;
  logic [31:0] target;
  logic        target_mis;
  assign target     = pcTargete & ~32'h0000_0003;
  assign target_mis = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic        in_req, in_wait, in_trap;
  logic        consume, outstanding;
  logic        have_instr, trap_mark;
  logic [31:0] instr_src;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_req   = (state_q == S_REQ);
  assign in_wait  = (state_q == S_WAIT);
  assign in_trap  = (state_q == S_TRAP);
  assign consume  = imem_rdy & (in_req | (in_wait & ~kill_q));
  // A response still owed by memory after this cycle; a redirect must wait it out.
  assign outstanding = ~imem_rdy & (in_req | in_wait | (in_trap & kill_q));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    hold_d     = hold_q;
    have_instr = 1'b0;
    trap_mark  = 1'b0;
    instr_src  = NOP_INSTR;
    if (pcSrce) begin
      pc_d   = target;
      kill_d = outstanding;
      if (target_mis) begin
        state_d = S_TRAP;
      end else begin
        state_d = outstanding ? S_WAIT : S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ, S_WAIT: begin
          if (consume) begin
            if (stallf) begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end else begin
              have_instr = 1'b1;
              instr_src  = imem_rdata;
              pc_d       = pc_plus4;
              state_d    = S_REQ;
            end
          end else if (in_wait && kill_q && imem_rdy) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!stallf && !stalld) begin
            have_instr = 1'b1;
            instr_src  = hold_q;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end
        end
        default: begin
          trap_mark = 1'b1;
          if (kill_q && imem_rdy) begin
            kill_d = 1'b0;
          end
        end
      endcase
    end
  end

  // IF/ID: flush beats stall beats load; bubbles keep the last pc fields.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (flushd) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (!stalld) begin
      if (have_instr) begin
        instr_d = instr_src;
        pcd_d   = pc_q;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        mis_d   = 1'b0;
      end else if (trap_mark) begin
        instr_d = NOP_INSTR;
        pcd_d   = pc_q;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        mis_d   = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        mis_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req   = rst_n & in_req;
  assign imem_addr  = pc_q;
  assign fetch_wait = in_wait;
  assign instrd     = instr_q;
  assign pcd        = pcd_q;
  assign pcPlus4d   = pcp4_q;
  assign validd     = valid_q;
  assign misalignd  = mis_q & MIS_EN;

endmodule

`default_nettype wire
